// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI/SRAM constants, bridge state encoding and byte-strobe helper
package axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_AR,
        ST_RD_R,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RESP
    } bridge_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0] SRAM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] SRAM_SIZE_HALF = 2'd1;
    localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

    // Size code 3 falls through to the full-word strobe.
    function automatic logic [3:0] sram_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SRAM_SIZE_BYTE: return 4'b0001 << addr_lo;
            SRAM_SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sram_strb_gen.sv
// rtl/sram_strb_gen.sv - byte-lane write strobe from SRAM size code and address low bits
module sram_strb_gen
    import axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    assign wstrb = sram_wstrb(size, addr_lo);

endmodule

// File: rtl/sram_axi_bridge.sv
// rtl/sram_axi_bridge.sv - SRAM-like request port to single-beat AXI4 master, one request at a time
// Optional: SRAM_AXI_BRIDGE_RESP_ERR_EN reports non-OKAY rresp/bresp on data_err.
module sram_axi_bridge
    import axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        data_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata_axi,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic        awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata_axi,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    bridge_state_e state;
    logic [1:0]    size_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          aw_done;
    logic          w_done;
    logic [1:0]    size_n;
    logic          aw_fire;
    logic          w_fire;

    assign addr_ok = req && (state == ST_IDLE || state == ST_RESP);
    assign size_n  = (size == 2'd3) ? SRAM_SIZE_WORD : size;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wdata_axi = wdata_q;
    assign wlast     = 1'b1;

    sram_strb_gen u_strb (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .wstrb   (wstrb)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
            data_ok <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            case (state)
                // RESP doubles as an accept slot so back-to-back requests see no bubble.
                ST_IDLE, ST_RESP: begin
                    data_ok <= 1'b0;
                    if (req) begin
                        size_q  <= size_n;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (wr) begin
                            state   <= ST_WR_AW_W;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            state   <= ST_RD_AR;
                            arvalid <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (rvalid) begin
                        rready  <= 1'b0;
                        rdata   <= rdata_axi;
                        data_ok <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_WR_AW_W: begin
                    if (aw_fire) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    // Flags clear here so the next write starts clean.
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        data_ok <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
    logic [1:0] resp_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_q <= AXI_RESP_OKAY;
        end else if (state == ST_RD_R && rvalid) begin
            resp_q <= rresp;
        end else if (state == ST_WR_B && bvalid) begin
            resp_q <= bresp;
        end
    end

    assign data_err = data_ok && (resp_q != AXI_RESP_OKAY);
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
    assign data_err    = 1'b0;
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb/tb_sram_axi_bridge.sv - directed vector bench for sram_axi_bridge
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok, data_err;
    logic [31:0] rdata;
    logic [3:0]  arid, awid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, wdata_axi, rdata_axi;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arlock, awlock, arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int total = 0;
    int bad   = 0;

`ifdef SRAM_AXI_BRIDGE_RESP_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    sram_axi_bridge #(.AXI_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .data_err(data_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata_axi(rdata_axi), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] slave_rdata;
        logic [3:0]  exp_wstrb;
        logic [2:0]  exp_axsize;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Zero-wait transaction: handshake cycle 0, channel cycle 1, response cycle 2, data_ok cycle 3.
    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        req = 1'b1; wr = v.wr; size = v.size; addr = v.addr; wdata = v.wdata;
        settle();
        chk({s, ".addr_ok"}, {31'd0, addr_ok}, 32'd1);
        tick();
        req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        settle();
        if (!v.wr) begin
            chk({s, ".arvalid"}, {31'd0, arvalid}, 32'd1);
            chk({s, ".araddr"}, araddr, v.addr);
            chk({s, ".arsize"}, {29'd0, arsize}, {29'd0, v.exp_axsize});
            arready = 1'b1;
            tick();
            arready = 1'b0;
            settle();
            chk({s, ".rready"}, {31'd0, rready}, 32'd1);
            rvalid = 1'b1; rdata_axi = v.slave_rdata; rresp = 2'b00;
            tick();
            rvalid = 1'b0; rdata_axi = 32'h0;
            settle();
            chk({s, ".data_ok"}, {31'd0, data_ok}, 32'd1);
            chk({s, ".rdata"}, rdata, v.slave_rdata);
        end else begin
            chk({s, ".awvalid"}, {31'd0, awvalid}, 32'd1);
            chk({s, ".wvalid"}, {31'd0, wvalid}, 32'd1);
            chk({s, ".awaddr"}, awaddr, v.addr);
            chk({s, ".awsize"}, {29'd0, awsize}, {29'd0, v.exp_axsize});
            chk({s, ".wstrb"}, {28'd0, wstrb}, {28'd0, v.exp_wstrb});
            chk({s, ".wdata_axi"}, wdata_axi, v.wdata);
            awready = 1'b1; wready = 1'b1;
            tick();
            awready = 1'b0; wready = 1'b0;
            settle();
            chk({s, ".bready"}, {31'd0, bready}, 32'd1);
            chk({s, ".awvalid_drop"}, {31'd0, awvalid}, 32'd0);
            bvalid = 1'b1; bresp = 2'b00;
            tick();
            bvalid = 1'b0;
            settle();
            chk({s, ".data_ok"}, {31'd0, data_ok}, 32'd1);
        end
        tick();
        chk({s, ".data_ok_pulse"}, {31'd0, data_ok}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
        arready = 1'b0; rdata_axi = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

        vecs[0] = '{1'b0, 2'd2, 32'h1FC0_0004, 32'h0, 32'hDEAD_BEEF, 4'b1111, 3'd2};
        vecs[1] = '{1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 32'h0, 4'b1000, 3'd0};
        vecs[2] = '{1'b1, 2'd0, 32'h8000_0001, 32'h0000_CD00, 32'h0, 4'b0010, 3'd0};
        vecs[3] = '{1'b1, 2'd1, 32'h8000_0002, 32'h1234_0000, 32'h0, 4'b1100, 3'd1};
        vecs[4] = '{1'b1, 2'd1, 32'h8000_0000, 32'h0000_5678, 32'h0, 4'b0011, 3'd1};
        vecs[5] = '{1'b1, 2'd2, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 4'b1111, 3'd2};
        vecs[6] = '{1'b1, 2'd3, 32'h8000_0020, 32'h0BAD_CAFE, 32'h0, 4'b1111, 3'd2};
        vecs[7] = '{1'b0, 2'd0, 32'h0000_0007, 32'h0, 32'h0000_0055, 4'b0001, 3'd0};

        tick();
        chk("rst.addr_ok", {31'd0, addr_ok}, 32'd0);
        chk("rst.data_ok", {31'd0, data_ok}, 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk("rst.data_err", {31'd0, data_err}, 32'd0);
        chk("rst.valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        resetn = 1'b1;
        tick();
        chk("const.arid_awid", {24'd0, arid, awid}, 32'h11);
        chk("const.lens", {16'd0, arlen, awlen}, 32'd0);
        chk("const.bursts", {28'd0, arburst, awburst}, 32'h5);
        chk("const.misc", {16'd0, arlock, awlock, arcache, awcache, arprot[1:0], awprot[1:0]}, 32'd0);
        chk("const.hi_prot_wlast", {29'd0, arprot[2], awprot[2], wlast}, 32'd1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Byte write with awready delayed to cycle 5, immediate wready, bvalid in cycle 7.
        req = 1'b1; wr = 1'b1; size = 2'd0; addr = 32'h8000_0003; wdata = 32'hAB00_0000;
        settle();
        chk("dly.addr_ok", {31'd0, addr_ok}, 32'd1);
        tick();
        req = 1'b0;
        wready = 1'b1;
        settle();
        chk("dly.wstrb", {28'd0, wstrb}, 32'h8);
        chk("dly.awsize", {29'd0, awsize}, 32'd0);
        tick();
        wready = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            settle();
            chk($sformatf("dly.c%0d.wvalid", c), {31'd0, wvalid}, 32'd0);
            chk($sformatf("dly.c%0d.awvalid", c), {31'd0, awvalid}, 32'd1);
            tick();
        end
        awready = 1'b1;
        settle();
        chk("dly.c5.bready", {31'd0, bready}, 32'd0);
        tick();
        awready = 1'b0;
        chk("dly.c6.bready", {31'd0, bready}, 32'd1);
        chk("dly.c6.awvalid", {31'd0, awvalid}, 32'd0);
        tick();
        bvalid = 1'b1;
        settle();
        chk("dly.c7.data_ok", {31'd0, data_ok}, 32'd0);
        tick();
        bvalid = 1'b0;
        chk("dly.c8.data_ok", {31'd0, data_ok}, 32'd1);
        tick();
        chk("dly.c9.data_ok", {31'd0, data_ok}, 32'd0);

        // Back-to-back: read, then a write offered in the RESP cycle.
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_1000;
        tick();
        req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0102_0304;
        tick();
        rvalid = 1'b0;
        req = 1'b1; wr = 1'b1; size = 2'd1; addr = 32'h0000_2002; wdata = 32'hBEEF_0000;
        settle();
        chk("b2b.data_ok", {31'd0, data_ok}, 32'd1);
        chk("b2b.addr_ok", {31'd0, addr_ok}, 32'd1);
        chk("b2b.rdata", rdata, 32'h0102_0304);
        tick();
        req = 1'b0;
        chk("b2b.awvalid", {31'd0, awvalid}, 32'd1);
        chk("b2b.wstrb", {28'd0, wstrb}, 32'hC);
        chk("b2b.data_ok_low", {31'd0, data_ok}, 32'd0);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("b2b.w_data_ok", {31'd0, data_ok}, 32'd1);
        tick();

        // Asynchronous reset while in RD_R, with rvalid arriving around the release.
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_3000;
        tick();
        req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rst2.rready_pre", {31'd0, rready}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst2.rready_async", {31'd0, rready}, 32'd0);
        chk("rst2.arvalid_async", {31'd0, arvalid}, 32'd0);
        tick();
        rvalid = 1'b1; rdata_axi = 32'h7777_7777;
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rst2.c%0d.data_ok", c), {31'd0, data_ok}, 32'd0);
            chk($sformatf("rst2.c%0d.rready", c), {31'd0, rready}, 32'd0);
        end
        rvalid = 1'b0;
        chk("rst2.rdata", rdata, 32'd0);
        req = 1'b1;
        settle();
        chk("rst2.idle_addr_ok", {31'd0, addr_ok}, 32'd1);
        req = 1'b0;
        settle();
        tick();

        // Read with SLVERR response.
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_4000;
        tick();
        req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata_axi = 32'hA5A5_5A5A;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("err.data_ok", {31'd0, data_ok}, 32'd1);
        chk("err.data_err", {31'd0, data_err}, {31'd0, ERR_EXP});
        chk("err.rdata", rdata, 32'hA5A5_5A5A);
        tick();
        chk("err.data_err_after", {31'd0, data_err}, 32'd0);

        // arready stalled for 20 cycles while the core keeps offering a new request.
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1FC0_0100;
        tick();
        addr = 32'h0000_BEEF;
        begin
            int stable_bad = 0;
            for (int c = 0; c < 20; c++) begin
                settle();
                if (!arvalid || araddr !== 32'h1FC0_0100 || addr_ok) stable_bad++;
                tick();
            end
            chk("stall.stable_cycles_bad", stable_bad, 32'd0);
        end
        chk("stall.arvalid", {31'd0, arvalid}, 32'd1);
        req = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0000_0001;
        begin
            int waited = 0;
            tick();
            rvalid = 1'b0;
            while (!data_ok && waited < 10) begin
                tick();
                waited++;
            end
            chk("stall.done_wait", waited, 32'd0);
        end
        chk("stall.rdata", rdata, 32'h0000_0001);
        tick();
        chk("stall.idle", {31'd0, data_ok}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
